// File: rtl/stage_pipe_pkg.sv
// rtl/stage_pipe_pkg.sv - shared FSM state types, protocol selectors and pointer helper
package stage_pipe_pkg;

  typedef enum logic {IN_IDLE, IN_RTZ} in_state_t;

  typedef enum logic [1:0] {OUT_IDLE, OUT_REQ, OUT_RTZ} out_state_t;

  localparam bit PROTO_2PH = 1'b0;
  localparam bit PROTO_4PH = 1'b1;

  // Pointer increment modulo an arbitrary (non power-of-two) depth.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1 == depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/stage_param_pipe_if.sv
// rtl/stage_param_pipe_if.sv - upstream/downstream handshake channels plus status
interface stage_param_pipe_if #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 3
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             req_in;
  logic             ack_out;
  logic [WIDTH-1:0] data_in;
  logic             req_out;
  logic             ack_in;
  logic [WIDTH-1:0] data_out;
  logic [CW-1:0]    count;
  logic             proto_err;

  modport master (
    output req_in, data_in, ack_in,
    input  ack_out, req_out, data_out, count, proto_err
  );

  modport slave (
    input  req_in, data_in, ack_in,
    output ack_out, req_out, data_out, count, proto_err
  );

endinterface

// File: rtl/stage_param_pipe_hs_sync.sv
// rtl/stage_param_pipe_hs_sync.sv - STAGES-deep flop synchroniser, wire bypass when STAGES=0
module hs_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign q = d;
    end else begin : g_chain
      logic [STAGES-1:0] sync_q;
      logic [STAGES-1:0] sync_d;

      always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = d;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_q <= '0;
        end else begin
          sync_q <= sync_d;
        end
      end

      assign q = sync_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/stage_param_pipe.sv
// rtl/stage_param_pipe.sv - parametrised req/ack token pipeline with DEPTH-entry FIFO
// Input and output FSMs share the FIFO; 2-phase or 4-phase selected by FOUR_PHASE.
module stage_param_pipe
  import stage_pipe_pkg::*;
#(
  parameter int WIDTH       = 3,
  parameter int DEPTH       = 3,
  parameter int SYNC_STAGES = 2,
  parameter bit FOUR_PHASE  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  stage_param_pipe_if.slave  bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic req_s;
  logic ack_s;

  hs_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (bus.req_in),
    .q     (req_s)
  );

  hs_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (bus.ack_in),
    .q     (ack_s)
  );

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ack_out_q, ack_out_d;
  logic             req_out_q, req_out_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             proto_err_q, proto_err_d;
  logic             ack_prev_q, ack_prev_d;
  in_state_t        in_state_q, in_state_d;
  out_state_t       out_state_q, out_state_d;

  logic push;
  logic pop;
  logic not_full;
  logic not_empty;
  logic ack_evt;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ack_out_d   = ack_out_q;
    req_out_d   = req_out_q;
    data_out_d  = data_out_q;
    proto_err_d = proto_err_q;
    ack_prev_d  = ack_s;
    in_state_d  = in_state_q;
    out_state_d = out_state_q;
    push        = 1'b0;
    pop         = 1'b0;
    not_full    = (count_q < CW'(DEPTH));
    not_empty   = (count_q != '0);
    // An ack "event" is any edge in 2-phase, only a rising edge in 4-phase.
    ack_evt     = (FOUR_PHASE == PROTO_4PH) ? (ack_s & ~ack_prev_q) : (ack_s ^ ack_prev_q);

    if (FOUR_PHASE == PROTO_4PH) begin
      case (in_state_q)
        IN_IDLE: begin
          if (req_s && not_full) begin
            push       = 1'b1;
            ack_out_d  = 1'b1;
            in_state_d = IN_RTZ;
          end
        end
        IN_RTZ: begin
          if (!req_s) begin
            ack_out_d  = 1'b0;
            in_state_d = IN_IDLE;
          end
        end
        default: in_state_d = IN_IDLE;
      endcase
    end else if ((req_s != ack_out_q) && not_full) begin
      push      = 1'b1;
      ack_out_d = ~ack_out_q;
    end

    case (out_state_q)
      OUT_IDLE: begin
        if (ack_evt) begin
          proto_err_d = 1'b1;
        end else if (not_empty) begin
          data_out_d  = mem_q[rd_ptr_q];
          req_out_d   = (FOUR_PHASE == PROTO_4PH) ? 1'b1 : ~req_out_q;
          out_state_d = OUT_REQ;
        end
      end
      OUT_REQ: begin
        if (FOUR_PHASE == PROTO_4PH) begin
          if (ack_s) begin
            pop         = 1'b1;
            req_out_d   = 1'b0;
            out_state_d = OUT_RTZ;
          end
        end else if (ack_s == req_out_q) begin
          pop         = 1'b1;
          out_state_d = OUT_IDLE;
        end
      end
      OUT_RTZ: begin
        if (ack_evt) begin
          proto_err_d = 1'b1;
        end else if (!ack_s) begin
          out_state_d = OUT_IDLE;
        end
      end
      default: out_state_d = OUT_IDLE;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = bus.data_in;
      wr_ptr_d        = PW'(wrap_inc(32'(wr_ptr_q), DEPTH));
    end
    if (pop) begin
      rd_ptr_d = PW'(wrap_inc(32'(rd_ptr_q), DEPTH));
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ack_out_q   <= 1'b0;
      req_out_q   <= 1'b0;
      data_out_q  <= '0;
      proto_err_q <= 1'b0;
      ack_prev_q  <= 1'b0;
      in_state_q  <= IN_IDLE;
      out_state_q <= OUT_IDLE;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ack_out_q   <= ack_out_d;
      req_out_q   <= req_out_d;
      data_out_q  <= data_out_d;
      proto_err_q <= proto_err_d;
      ack_prev_q  <= ack_prev_d;
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
    end
  end

  assign bus.ack_out   = ack_out_q;
  assign bus.req_out   = req_out_q;
  assign bus.data_out  = data_out_q;
  assign bus.count     = count_q;
  assign bus.proto_err = proto_err_q;

endmodule

// File: doc/stage_param_pipe.md
Name: stage_param_pipe

Overview:
- Parametrised, clocked successor to the fixed 3-stage req/ack data pipeline.
- Accepts bundled-data tokens on a req_in/ack_out channel and buffers them in a DEPTH-entry FIFO.
- Re-issues tokens in order on a req_out/ack_in channel.
- Supports 2-phase (transition) or 4-phase (return-to-zero) signalling, with optional synchronisers on the incoming handshake wires.

Parameters:
- WIDTH, 3: data token width in bits.
- DEPTH, 3: FIFO entries; DEPTH >= 2.
- SYNC_STAGES, 2: flops on req_in and ack_in; 0 = bypass, inputs already synchronous to clk.
- FOUR_PHASE, 0: 0 = 2-phase protocol, 1 = 4-phase protocol.

Ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_in  in  1  upstream request.
- ack_out  out  1  upstream acknowledge.
- data_in  in  WIDTH  upstream data; must be stable from the req_in event until the ack_out event.
- req_out  out  1  downstream request.
- ack_in  in  1  downstream acknowledge.
- data_out  out  WIDTH  downstream data; registered, stable while a request is outstanding.
- count  out  $clog2(DEPTH+1)  FIFO occupancy.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- **Reset.** rst low at any time, asynchronously, sets:
  - outputs req_out, ack_out, data_out, count and proto_err to 0;
  - sync chains, phase registers, FIFO pointers and both FSMs to idle/0.
- **Reset mid-operation.** All buffered tokens are discarded. Handshakes resume from phase 0 after rst returns high.
- **Synchronisers.** req_s and ack_s are the outputs of SYNC_STAGES-deep chains. An input change before edge E0 is visible in req_s/ack_s after edge E(SYNC_STAGES-1). With SYNC_STAGES=0, req_s/ack_s are the raw inputs.
- **Input FSM, 2-phase.**
  - Request pending when req_s != ack_out.
  - If pending and count < DEPTH: on that edge push data_in and toggle ack_out.
  - Net latency: req_in change before E0 -> ack_out toggles at edge E(SYNC_STAGES).
- **Input FSM, 4-phase.** States IN_IDLE, IN_RTZ.
  - IN_IDLE: req_s=1 and count < DEPTH -> push, ack_out<=1, go to IN_RTZ.
  - IN_RTZ: req_s=0 -> ack_out<=0, go to IN_IDLE.
- **Full.** A request is held unacknowledged while count == DEPTH. It is accepted on the first edge where count < DEPTH. There is no same-cycle pass-through when full: a pop at edge E enables a push at edge E+1 at the earliest.
- **Output FSM, 2-phase.** States OUT_IDLE, OUT_REQ.
  - OUT_IDLE, FIFO non-empty: load data_out from the head, toggle req_out, go to OUT_REQ.
  - OUT_REQ: ack_s == req_out -> pop, go to OUT_IDLE.
- **Output FSM, 4-phase.** States OUT_IDLE, OUT_REQ, OUT_RTZ.
  - OUT_IDLE, non-empty: load data_out, req_out<=1, go to OUT_REQ.
  - OUT_REQ: ack_s=1 -> pop, req_out<=0, go to OUT_RTZ.
  - OUT_RTZ: ack_s=0 -> go to OUT_IDLE.
- **Output latency.** A push at edge E into an empty FIFO gives req_out/data_out at edge E+1.
- **count.**
  - +1 on push, -1 on pop, unchanged on simultaneous push and pop.
  - Never exceeds DEPTH and never wraps.
  - Pointers wrap modulo DEPTH; DEPTH need not be a power of 2.
- **proto_err.** Set to 1, sticky until reset, when an ack_s event occurs with no outstanding request:
  - 2-phase: ack_s changes while in OUT_IDLE.
  - 4-phase: ack_s rises in OUT_IDLE or OUT_RTZ.
  - The event causes no pop and no state change.
- **Ordering.** data_out order always equals data_in acceptance order.

Decomposition:
- Package stage_pipe_pkg holds:
  - in_state_t {IN_IDLE, IN_RTZ};
  - out_state_t {OUT_IDLE, OUT_REQ, OUT_RTZ};
  - constants PROTO_2PH=0, PROTO_4PH=1.
- Sub-module hs_sync(STAGES): N-flop synchroniser, async active-low reset to 0, bypass when STAGES=0. Instantiated twice, for req_in and ack_in.
- FIFO storage and both FSMs live in stage_param_pipe.

Test Plan:
1. 2-phase, defaults: release rst; req_in 0->1 with data_in=1 before E0 -> ack_out=1 at E2, req_out=1 and data_out=1 at E3, count=1 then 0 after ack_in 0->1 is synchronised.
2. Full, 2-phase, ack_in held: 4 tokens 1,2,3,4 -> tokens 1-3 acknowledged, count=3, 4th request unacknowledged. Then toggle ack_in -> 4th acknowledged one edge after the pop. Output order is 1,2,3,4.
3. FOUR_PHASE=1: req_in=1 with data_in=5 -> ack_out=1; req_in=0 -> ack_out=0. Output: req_out=1, data_out=5; ack_in=1 -> req_out=0; ack_in=0 -> OUT_IDLE, count=0.
4. Reset mid-operation with count=2: pull rst low between edges -> req_out, ack_out, count and data_out all 0 immediately. After release, a new token 6 is delivered as the first output.
5. Spurious ack_in toggle with the FIFO empty -> proto_err=1 and count stays 0. A following normal transfer still completes, and proto_err stays 1 until rst.
6. SYNC_STAGES=0: req_in change before E0 -> ack_out at E0, req_out at E1.
